// File: rtl/free_list.sv
// Physical-tag free list for register rename.
// Multi-slot alloc from head, packed commit frees at tail.
module free_list #(
  parameter int NUM_TAGS = 64,
  parameter int NUM_ARCH = 15,
  parameter int WIDTH    = 3,
  localparam int TW = $clog2(NUM_TAGS),
  localparam int CW = $clog2(NUM_TAGS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         alloc_req_i,
  output logic [WIDTH-1:0][TW-1:0] alloc_tags_o,
  output logic                     alloc_gnt_o,
  input  logic [WIDTH-1:0]         free_valid_i,
  input  logic [WIDTH-1:0][TW-1:0] free_tags_i,
  output logic [CW-1:0]            count_o,
  output logic                     empty_o,
  output logic                     overflow_err_o
);

  localparam int NINIT = NUM_TAGS - NUM_ARCH;

  logic [TW-1:0] mem [NUM_TAGS];
  logic [TW-1:0] head;
  logic [TW-1:0] tail;
  logic [CW-1:0] count;
  logic          ovf;

  logic [CW:0]   n_req;
  logic [CW:0]   n_gnt;
  logic [CW:0]   cap;
  logic [CW:0]   n_acc;
  logic [CW-1:0] count_nx;
  logic          drop;

  logic [WIDTH-1:0]         wr_en;
  logic [WIDTH-1:0][TW-1:0] wr_addr;

  always_comb begin
    n_req = '0;
    for (int k = 0; k < WIDTH; k++)
      n_req = n_req + (CW+1)'(alloc_req_i[k]);
    alloc_gnt_o = (n_req <= {1'b0, count});
    n_gnt = alloc_gnt_o ? n_req : '0;
  end

  // Requesting slots read consecutive entries from head.
  always_comb begin
    logic [TW-1:0] off;
    off = '0;
    alloc_tags_o = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (alloc_req_i[k] && alloc_gnt_o)
        alloc_tags_o[k] = mem[head + off];
      if (alloc_req_i[k])
        off = off + TW'(1);
    end
  end

  // Capacity counts room freed by this cycle's grant.
  always_comb begin
    cap = (CW+1)'(NUM_TAGS) - {1'b0, count} + n_gnt;
    n_acc = '0;
    wr_en = '0;
    wr_addr = '0;
    drop = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      if (free_valid_i[k]) begin
        if (n_acc < cap) begin
          wr_en[k] = 1'b1;
          wr_addr[k] = tail + n_acc[TW-1:0];
          n_acc = n_acc + (CW+1)'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
    count_nx = count - n_gnt[CW-1:0]
             + n_acc[CW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= TW'(NINIT);
      count <= CW'(NINIT);
      ovf   <= 1'b0;
      for (int i = 0; i < NUM_TAGS; i++)
        mem[i] <= (i < NINIT) ? TW'(i + NUM_ARCH) : '0;
    end else begin
      head  <= head + n_gnt[TW-1:0];
      tail  <= tail + n_acc[TW-1:0];
      count <= count_nx;
      if (drop)
        ovf <= 1'b1;
      for (int k = 0; k < WIDTH; k++)
        if (wr_en[k])
          mem[wr_addr[k]] <= free_tags_i[k];
    end
  end

  assign count_o        = count;
  assign empty_o        = (count == '0);
  assign overflow_err_o = ovf;

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list.
// Driver queues expected outputs; negedge monitor compares.
module tb_free_list;

  logic            clk;
  logic            rst;
  logic [2:0]      alloc_req_i;
  logic [2:0][5:0] alloc_tags_o;
  logic            alloc_gnt_o;
  logic [2:0]      free_valid_i;
  logic [2:0][5:0] free_tags_i;
  logic [6:0]      count_o;
  logic            empty_o;
  logic            overflow_err_o;

  free_list dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_req_i    (alloc_req_i),
    .alloc_tags_o   (alloc_tags_o),
    .alloc_gnt_o    (alloc_gnt_o),
    .free_valid_i   (free_valid_i),
    .free_tags_i    (free_tags_i),
    .count_o        (count_o),
    .empty_o        (empty_o),
    .overflow_err_o (overflow_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic            gnt;
    logic [2:0][5:0] tags;
    logic [6:0]      cnt;
    logic            emp;
    logic            ovf;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (alloc_gnt_o !== e.gnt || alloc_tags_o !== e.tags ||
          count_o !== e.cnt || empty_o !== e.emp ||
          overflow_err_o !== e.ovf) begin
        bad++;
        $display("FAIL %s: got gnt=%0b tags=%0d,%0d,%0d cnt=%0d emp=%0b ovf=%0b want gnt=%0b tags=%0d,%0d,%0d cnt=%0d emp=%0b ovf=%0b",
          e.name, alloc_gnt_o, alloc_tags_o[0], alloc_tags_o[1],
          alloc_tags_o[2], count_o, empty_o, overflow_err_o,
          e.gnt, e.tags[0], e.tags[1], e.tags[2], e.cnt, e.emp,
          e.ovf);
      end
    end
  end

  task automatic step(
    input string      nm,
    input logic [2:0] req,
    input logic [2:0] fv,
    input logic [5:0] f0, input logic [5:0] f1,
    input logic [5:0] f2,
    input logic       eg,
    input logic [5:0] t0, input logic [5:0] t1,
    input logic [5:0] t2,
    input logic [6:0] ec,
    input logic       eo
  );
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b0;
    alloc_req_i = req;
    free_valid_i = fv;
    free_tags_i = {f2, f1, f0};
    e.name = nm;
    e.gnt  = eg;
    e.tags = {t2, t1, t0};
    e.cnt  = ec;
    e.emp  = (ec == 7'd0);
    e.ovf  = eo;
    q.push_back(e);
  endtask

  // Junk requests during reset must be discarded.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    alloc_req_i = 3'b111;
    free_valid_i = 3'b111;
    free_tags_i = {6'd7, 6'd8, 6'd9};
  endtask

  logic [5:0] order[$];
  logic [5:0] nt;
  logic [5:0] ex [3];

  initial begin
    rst = 1'b1;
    alloc_req_i = '0;
    free_valid_i = '0;
    free_tags_i = '0;
    repeat (2) @(posedge clk);

    do_reset();
    step("rst_state", 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 49, 0);
    step("alloc3", 3'b111, 3'b000, 0, 0, 0, 1, 15, 16, 17, 49, 0);
    step("cnt46", 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 46, 0);

    do_reset();
    step("alloc101", 3'b101, 3'b000, 0, 0, 0, 1, 15, 0, 16, 49, 0);
    step("alloc001", 3'b001, 3'b000, 0, 0, 0, 1, 17, 0, 0, 47, 0);
    nt = 6'd18;
    for (int i = 0; i < 14; i++) begin
      step("drain", 3'b111, 3'b000, 0, 0, 0, 1,
           nt, nt + 6'd1, nt + 6'd2, 7'(46 - 3 * i), 0);
      nt = nt + 6'd3;
    end
    step("drain2", 3'b011, 3'b000, 0, 0, 0, 1, 60, 61, 0, 4, 0);
    step("deny", 3'b111, 3'b000, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    step("last2", 3'b011, 3'b000, 0, 0, 0, 1, 62, 63, 0, 2, 0);
    step("empty", 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("nobypass", 3'b001, 3'b101, 5, 0, 9, 0, 0, 0, 0, 0, 0);
    step("freed", 3'b011, 3'b000, 0, 0, 0, 1, 5, 9, 0, 2, 0);
    step("empty2", 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Wrap: three alloc/free pairs per cycle, count steady at 49.
    do_reset();
    for (int i = 0; i < 62; i++) begin
      for (int s = 0; s < 3; s++) begin
        int k;
        k = 3 * i + s;
        ex[s] = (k < 49) ? 6'(15 + k) : 6'(k - 49);
      end
      step("wrap", 3'b111, 3'b111,
           6'(3 * i), 6'(3 * i + 1), 6'(3 * i + 2), 1,
           ex[0], ex[1], ex[2], 49, 0);
    end
    step("wrap_cnt", 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 49, 0);

    // Fill toward capacity, then overflow.
    do_reset();
    for (int i = 0; i < 4; i++)
      step("fill", 3'b000, 3'b111,
           6'(1 + 3 * i), 6'(2 + 3 * i), 6'(3 + 3 * i), 1,
           0, 0, 0, 7'(49 + 3 * i), 0);
    step("fill2", 3'b000, 3'b011, 13, 14, 0, 1, 0, 0, 0, 61, 0);
    step("alloc_free", 3'b001, 3'b011, 40, 41, 0, 1,
         15, 0, 0, 63, 0);
    step("full_noovf", 3'b001, 3'b000, 0, 0, 0, 1,
         16, 0, 0, 64, 0);
    step("ovf_push", 3'b000, 3'b111, 20, 21, 22, 1,
         0, 0, 0, 63, 0);
    step("ovf_set", 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 64, 1);
    step("ovf_hold", 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 64, 1);

    for (int v = 17; v <= 63; v++) order.push_back(6'(v));
    for (int v = 1; v <= 14; v++) order.push_back(6'(v));
    order.push_back(6'd40);
    order.push_back(6'd41);
    order.push_back(6'd20);
    for (int i = 0; i < 21; i++) begin
      ex[0] = order.pop_front();
      ex[1] = order.pop_front();
      ex[2] = order.pop_front();
      step("order", 3'b111, 3'b000, 0, 0, 0, 1,
           ex[0], ex[1], ex[2], 7'(64 - 3 * i), 1);
    end
    ex[0] = order.pop_front();
    step("order_last", 3'b001, 3'b000, 0, 0, 0, 1,
         ex[0], 0, 0, 1, 1);
    step("drained", 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 1);

    do_reset();
    step("rst_clear", 3'b000, 3'b000, 0, 0, 0, 1, 0, 0, 0, 49, 0);

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_q: got %0d left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 The block SHALL have parameter NUM_TAGS, default 64, meaning the number of physical tags and the free-list depth.
REQ-002 The block SHALL have parameter NUM_ARCH, default 15, meaning the number of architectural registers holding tags 0..NUM_ARCH-1 at reset.
REQ-003 The block SHALL have parameter WIDTH, default 3, meaning the number of alloc and free slots per cycle.
REQ-004 Port clk  input  1  clock; all state updates on the rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port alloc_req_i  input  [2:0]  per-slot request from rename for one new destination tag.
REQ-007 Port alloc_tags_o  output  [2:0][5:0]  tag given to each requesting slot.
REQ-008 Port alloc_gnt_o  output  1  all requests this cycle granted.
REQ-009 Port free_valid_i  input  [2:0]  per-slot valid for a tag released by commit.
REQ-010 Port free_tags_i  input  [2:0][5:0]  tags released by commit.
REQ-011 Port count_o  output  [6:0]  number of free tags held, 0..64.
REQ-012 Port empty_o  output  1  high when count_o == 0.
REQ-013 Port overflow_err_o  output  1  sticky error flag for a free push beyond capacity.

Function
REQ-014 Storage SHALL be a circular buffer of 64 x 6-bit entries with 6-bit head and tail pointers that wrap modulo 64.
REQ-015 Let n_req = popcount(alloc_req_i); alloc_gnt_o SHALL be combinational and equal 1 when n_req <= count_o, including n_req == 0.
REQ-016 Allocation SHALL be all-or-nothing: when alloc_gnt_o == 0, the block SHALL consume no tags and SHALL leave head unchanged.
REQ-017 alloc_tags_o[k] SHALL equal mem[head + m], where m = number of set bits of alloc_req_i below slot k; the output is combinational from registered state, so read latency is 0.
REQ-018 alloc_tags_o[k] SHALL be 6'b0 for every slot with alloc_req_i[k] == 0 and for all slots when alloc_gnt_o == 0.
REQ-019 On a clock edge with alloc_gnt_o == 1, head SHALL advance by n_req.
REQ-020 Free pushes SHALL be packed in slot order: the valid slot with the j-th lowest index writes mem[tail + j], and tail advances by the number of pushes accepted.
REQ-021 Tags freed in a cycle SHALL NOT be visible to allocation in the same cycle (no bypass); they are allocatable from the next cycle.
REQ-022 count_next SHALL equal count - (alloc_gnt_o ? n_req : 0) + accepted_frees, computed in 8 bits with no wrap.
REQ-023 Simultaneous alloc and free SHALL both take effect in the same edge; free capacity SHALL be evaluated after the same-cycle allocation (64 - count + granted n_req).
REQ-024 Free pushes beyond that capacity SHALL be dropped, highest slot first, and overflow_err_o SHALL be set and held high until reset.
REQ-025 The block SHALL NOT check for duplicate tags or for tags < NUM_ARCH; that checking belongs to commit.

Reset
REQ-026 While rst is high at a clock edge, the block SHALL set head = 0, tail = 49, count = 49, overflow_err_o = 0, mem[i] = i + 15 for i = 0..48, and mem[49..63] = 0.
REQ-027 rst SHALL override any concurrent alloc or free; requests presented in the reset cycle SHALL be discarded.
REQ-028 After reset, empty_o SHALL be 0, count_o SHALL be 49, and alloc_tags_o SHALL follow REQ-017/REQ-018 from the reset state.

Verification
REQ-029 Reset, then alloc_req_i = 3'b111 -> tags {15,16,17}, alloc_gnt_o = 1; after the edge, count_o = 46.
REQ-030 Reset, then alloc_req_i = 3'b101 -> slot0 = 15, slot1 = 0, slot2 = 16; after the edge, the next 3'b001 request returns 17.
REQ-031 Drain to count_o = 2, then request 3'b111 -> alloc_gnt_o = 0, all tags 0; count stays 2 after the edge, and a 3'b011 request is then granted with count -> 0 and empty_o = 1.
REQ-032 At count_o = 0, free {5,9} in slots 0 and 2 while requesting 3'b001 -> no grant that cycle; next cycle request 3'b011 -> tags {5,9}.
REQ-033 Wrap: cycle 62 alloc/free pairs and confirm tags 15..63 then the freed tags are returned in order across the head and tail wrap at index 63 -> 0.
REQ-034 At count_o = 63, push 3 frees with no alloc -> 1 accepted (slot 0), count_o = 64, overflow_err_o = 1 and sticky; assert rst -> overflow_err_o = 0, count_o = 49.
